// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_fb_arbiter_pkg                                              |
// | Purpose  : Shared frame-buffer geometry, default widths and the swap FSM   |
// |            state type for the frame-buffer arbiter.                        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package vga_fb_arbiter_pkg;

   // Scaled frame buffer: the 640x480 display is shown from a 320x240 buffer.
   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FB_WORDS  = FB_W * FB_H;

   // Default widths: one bank addresses every buffer word, RGB444 pixels.
   localparam int FB_ADDR_W = $clog2(FB_WORDS);
   localparam int FB_DATA_W = 12;
   localparam int FB_CNT_W  = 16;

   typedef enum logic [0:0] {
      SWAP_IDLE = 1'b0,
      SWAP_PEND = 1'b1
   } swap_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_fb_arbiter_if                                               |
// | Purpose  : Bundles the display read port, pixel writer handshake, bank     |
// |            swap control/status and frame RAM port of the arbiter.          |
// | Modports : slave  - arbiter side                                           |
// |            master - environment side (timing controller, writer, RAM)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface vga_fb_arbiter_if
   import vga_fb_arbiter_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int CNT_W  = FB_CNT_W
);
   // display read path
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              frame_start;
   // pixel writer
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   // bank swap
   logic              swap_req;
   logic              swap_pending;
   logic              swap_done;
   logic              front_bank;
   logic [CNT_W-1:0]  wr_stall_cnt;
   // frame RAM
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_req, disp_addr, frame_start,
      input  wr_valid, wr_addr, wr_data, swap_req,
      input  mem_rdata,
      output disp_data, disp_valid, wr_ready,
      output swap_pending, swap_done, front_bank, wr_stall_cnt,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output disp_req, disp_addr, frame_start,
      output wr_valid, wr_addr, wr_data, swap_req,
      output mem_rdata,
      input  disp_data, disp_valid, wr_ready,
      input  swap_pending, swap_done, front_bank, wr_stall_cnt,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter_wr_hold.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_fb_arbiter_wr_hold                                          |
// | Purpose  : One-entry holding register for writer pixels (address + data).  |
// |            A loaded entry becomes visible the cycle after the load, so     |
// |            there is no combinational bypass from writer to RAM.            |
// | Ports    : px_clk, rst_n  clock / async active-low reset                   |
// |            load_i         capture addr_i/data_i                            |
// |            issue_i        entry consumed by the RAM this cycle             |
// |            addr_i/data_i  incoming pixel                                   |
// |            valid_o        entry present                                    |
// |            addr_o/data_o  held pixel                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vga_fb_arbiter_wr_hold
   import vga_fb_arbiter_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
) (
   input  wire logic              px_clk,
   input  wire logic              rst_n,
   input  wire logic              load_i,
   input  wire logic              issue_i,
   input  wire logic [ADDR_W-1:0] addr_i,
   input  wire logic [DATA_W-1:0] data_i,
   output logic                   valid_o,
   output logic      [ADDR_W-1:0] addr_o,
   output logic      [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   // Issue and load in the same cycle keeps the entry full with the new pixel,
   // giving one write per cycle while the display is idle.
   assign valid_d = load_i | (valid_q & ~issue_i);

   always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         if (load_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_fb_arbiter                                                  |
// | Purpose  : Shares one single-port synchronous frame RAM between display    |
// |            reads (absolute priority) and a buffered pixel writer. Front    |
// |            and back buffers live in one RAM split by the address MSB; a    |
// |            requested swap takes effect only at frame start.                |
// | Ports    : px_clk  pixel clock                                             |
// |            rst_n   asynchronous active-low reset                           |
// |            bus     vga_fb_arbiter_if.slave: display port, writer           |
// |                    handshake, swap control/status, stall counter, RAM      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int CNT_W  = FB_CNT_W
) (
   input  wire logic       px_clk,
   input  wire logic       rst_n,
   vga_fb_arbiter_if.slave bus
);

   // ---------------------------------------------------------------- hold ---
   logic              hold_valid;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   logic              wr_ready;
   logic              wr_load;
   logic              hold_issue;
   logic              wr_stall;

   swap_state_e       state_q;
   logic              front_q;
   logic              done_q;

   // Writes are frozen while a swap is pending so the back bank is complete
   // when it becomes the front bank.
   assign wr_ready   = (state_q == SWAP_IDLE) & (~hold_valid | ~bus.disp_req);
   assign wr_load    = bus.wr_valid & wr_ready;
   assign hold_issue = hold_valid & ~bus.disp_req;
   assign wr_stall   = bus.wr_valid & ~wr_ready;

   vga_fb_arbiter_wr_hold #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_hold (
      .px_clk  (px_clk),
      .rst_n   (rst_n),
      .load_i  (wr_load),
      .issue_i (hold_issue),
      .addr_i  (bus.wr_addr),
      .data_i  (bus.wr_data),
      .valid_o (hold_valid),
      .addr_o  (hold_addr),
      .data_o  (hold_data)
   );

   // Internal state is already held in reset; only the visible ready needs
   // masking so the writer sees no acceptance while rst_n is low.
   assign bus.wr_ready = rst_n & wr_ready;

   // ------------------------------------------------------- priority mux ---
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (bus.disp_req) begin
         mem_addr = {front_q, bus.disp_addr};
      end else if (hold_valid) begin
         mem_addr  = {~front_q, hold_addr};
         mem_we    = 1'b1;
         mem_wdata = hold_data;
      end
   end

   assign bus.mem_addr  = mem_addr;
   assign bus.mem_we    = mem_we;
   assign bus.mem_wdata = mem_wdata;

   // ------------------------------------------------------------ swap FSM ---
   // The hold must be empty at frame start: a write still in flight belongs to
   // the outgoing back bank, so the swap is deferred to the next frame start.
   always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SWAP_IDLE;
         front_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SWAP_IDLE: begin
               if (bus.swap_req) begin
                  state_q <= SWAP_PEND;
               end
            end
            SWAP_PEND: begin
               if (bus.frame_start && !hold_valid) begin
                  state_q <= SWAP_IDLE;
                  front_q <= ~front_q;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= SWAP_IDLE;
         endcase
      end
   end

   assign bus.swap_pending = (state_q == SWAP_PEND);
   assign bus.swap_done    = done_q;
   assign bus.front_bank   = front_q;

   // ------------------------------------------------ read-data pipeline ---
   // RAM data for a request at t arrives at t+1 and is registered for t+2.
   logic              req_d1_q;
   logic              disp_valid_q;
   logic [DATA_W-1:0] disp_data_q;

   always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d1_q     <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
      end else begin
         req_d1_q     <= bus.disp_req;
         disp_valid_q <= req_d1_q;
         if (req_d1_q) begin
            disp_data_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.disp_valid = disp_valid_q;
   assign bus.disp_data  = disp_data_q;

   // ------------------------------------------------------ stall counter ---
   // Frame start restarts the per-frame count, including a stall in that cycle.
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (bus.frame_start) begin
         stall_d = wr_stall ? CNT_W'(1) : '0;
      end else if (wr_stall && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.wr_stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_fb_arbiter                                               |
// | Purpose  : Self-checking bench for vga_fb_arbiter: frame RAM model, a      |
// |            transaction-level reference model compared every cycle, and     |
// |            directed scenarios with hand-computed expectations.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vga_fb_arbiter;

   localparam int AW        = 17;
   localparam int DW        = 12;
   localparam int CW        = 16;
   localparam int MEM_WORDS = 1 << (AW + 1);

   logic px_clk = 1'b0;
   logic rst_n  = 1'b0;

   always #5 px_clk = ~px_clk;

   vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

   vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .px_clk (px_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // ------------------------------------------------------------ frame RAM ---
   logic [DW-1:0] ram    [0:MEM_WORDS-1];
   logic [DW-1:0] shadow [0:MEM_WORDS-1];
   logic [DW-1:0] ram_rd_q = '0;

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i]    = DW'(i) ^ 12'h3C5;
         shadow[i] = DW'(i) ^ 12'h3C5;
      end
      ram[16]    = 12'hABC;
      shadow[16] = 12'hABC;
   end

   always @(posedge px_clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      ram_rd_q <= ram[bus.mem_addr];
   end
   assign bus.mem_rdata = ram_rd_q;

   // ----------------------------------------------------- reference model ---
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           m_hold[$];
   wr_t           m_w;
   bit            m_front = 0, m_pend = 0, m_done = 0, m_hv;
   bit            e_ready, e_we, e_stall;
   logic [AW:0]   e_addr;
   int            m_stall = 0;
   bit            pv0 = 0, pv1 = 0;
   logic [DW-1:0] pd0 = '0, pd1 = '0, m_last = '0, e_data;

   always @(negedge px_clk) begin
      if (!rst_n) begin
         chk("rst front_bank", bus.front_bank, 0);
         chk("rst wr_ready", bus.wr_ready, 0);
         chk("rst mem_we", bus.mem_we, 0);
         chk("rst swap_pending", bus.swap_pending, 0);
         chk("rst swap_done", bus.swap_done, 0);
         chk("rst disp_valid", bus.disp_valid, 0);
         chk("rst disp_data", bus.disp_data, 0);
         chk("rst wr_stall_cnt", bus.wr_stall_cnt, 0);
         m_hold.delete();
         m_front = 0; m_pend = 0; m_done = 0; m_stall = 0;
         pv0 = 0; pv1 = 0; m_last = '0;
      end else begin
         m_hv    = (m_hold.size() != 0);
         e_ready = !m_pend && (!m_hv || !bus.disp_req);
         if (bus.disp_req) begin
            e_we = 0; e_addr = {m_front, bus.disp_addr};
         end else if (m_hv) begin
            e_we = 1; e_addr = {!m_front, m_hold[0].a};
         end else begin
            e_we = 0; e_addr = '0;
         end
         chk("wr_ready", bus.wr_ready, e_ready);
         chk("mem_we", bus.mem_we, e_we);
         chk("mem_addr", bus.mem_addr, e_addr);
         if (e_we) chk("mem_wdata", bus.mem_wdata, m_hold[0].d);
         e_data = pv1 ? pd1 : m_last;
         m_last = e_data;
         chk("disp_valid", bus.disp_valid, pv1);
         chk("disp_data", bus.disp_data, e_data);
         chk("swap_pending", bus.swap_pending, m_pend);
         chk("swap_done", bus.swap_done, m_done);
         chk("front_bank", bus.front_bank, m_front);
         chk("wr_stall_cnt", bus.wr_stall_cnt, m_stall);

         // advance to the next cycle
         pv1 = pv0; pd1 = pd0;
         pv0 = bus.disp_req;
         pd0 = shadow[{m_front, bus.disp_addr}];
         if (m_hv && !bus.disp_req) begin
            shadow[{!m_front, m_hold[0].a}] = m_hold[0].d;
            void'(m_hold.pop_front());
         end
         e_stall = bus.wr_valid && !e_ready;
         if (bus.frame_start) m_stall = e_stall ? 1 : 0;
         else if (e_stall && m_stall < 65535) m_stall++;
         if (bus.wr_valid && e_ready) begin
            m_w.a = bus.wr_addr;
            m_w.d = bus.wr_data;
            m_hold.push_back(m_w);
         end
         m_done = 0;
         if (m_pend) begin
            if (bus.frame_start && !m_hv) begin
               m_pend = 0; m_front = !m_front; m_done = 1;
            end
         end else if (bus.swap_req) begin
            m_pend = 1;
         end
      end
   end

   // ------------------------------------------------------------ stimulus ---
   logic [AW-1:0] wr_a;
   logic [AW:0]   s_addr;
   logic [DW-1:0] s_wdata, s_data;
   logic [CW-1:0] s_stall;
   logic          s_ready, s_we, s_front, s_pend, s_done, s_valid;
   bit            acc;
   int            we_cnt, acc_cnt, done_cnt, rdy_cnt;

   // One clock cycle: snapshot outputs mid-cycle, then step past the edge and
   // present the writer's next pixel if the current one was accepted.
   task automatic cyc();
      @(negedge px_clk);
      s_ready = bus.wr_ready;   s_we    = bus.mem_we;     s_addr = bus.mem_addr;
      s_wdata = bus.mem_wdata;  s_front = bus.front_bank; s_pend = bus.swap_pending;
      s_done  = bus.swap_done;  s_valid = bus.disp_valid; s_data = bus.disp_data;
      s_stall = bus.wr_stall_cnt;
      if (bus.mem_we) we_cnt++;
      if (bus.swap_done) done_cnt++;
      if (bus.wr_ready) rdy_cnt++;
      acc = bus.wr_valid && bus.wr_ready;
      if (acc) acc_cnt++;
      @(posedge px_clk);
      #1;
      if (acc) begin
         wr_a         = wr_a + 1'b1;
         bus.wr_addr  = wr_a;
         bus.wr_data  = DW'(wr_a);
      end
   endtask

   initial begin
      bus.disp_req = 0; bus.disp_addr = '0; bus.frame_start = 0;
      bus.swap_req = 0; bus.wr_valid = 1;
      wr_a = 17'h00040; bus.wr_addr = wr_a; bus.wr_data = DW'(wr_a);
      we_cnt = 0; acc_cnt = 0; done_cnt = 0; rdy_cnt = 0;

      // reset with writer active
      cyc(); cyc();
      chk("reset wr_ready", s_ready, 0);
      chk("reset mem_we", s_we, 0);
      chk("reset front_bank", s_front, 0);
      rst_n = 1; bus.wr_valid = 0;
      cyc();
      chk("release wr_ready", s_ready, 1);

      // reset in the middle of a held write
      bus.disp_req = 1; bus.disp_addr = 17'd5; bus.wr_valid = 1;
      cyc(); cyc();
      chk("hold full wr_ready", s_ready, 0);
      rst_n = 0;
      cyc();
      chk("mid reset wr_ready", s_ready, 0);
      chk("mid reset mem_we", s_we, 0);
      chk("mid reset front_bank", s_front, 0);
      rst_n = 1; bus.disp_req = 0; bus.wr_valid = 0;
      cyc();
      chk("hold discarded mem_we", s_we, 0);
      chk("after reset wr_ready", s_ready, 1);

      // display read latency
      bus.disp_req = 1; bus.disp_addr = 17'h00010;
      cyc();
      bus.disp_req = 0;
      cyc();
      chk("disp_valid t+1", s_valid, 0);
      cyc();
      chk("disp_valid t+2", s_valid, 1);
      chk("disp_data t+2", s_data, 12'hABC);

      // active line starves writes
      bus.frame_start = 1;
      cyc();
      bus.frame_start = 0;
      wr_a = 17'h00100; bus.wr_addr = wr_a; bus.wr_data = DW'(wr_a);
      we_cnt = 0; acc_cnt = 0;
      bus.wr_valid = 1; bus.disp_req = 1;
      for (int i = 0; i < 640; i++) begin
         bus.disp_addr = AW'(i);
         cyc();
      end
      chk("active line mem_we count", we_cnt, 0);
      chk("active line accepted", acc_cnt, 1);
      bus.disp_req = 0;
      cyc();
      chk("stall count", s_stall, 639);
      chk("blank write 0 we", s_we, 1);
      chk("blank write 0 addr", s_addr, 18'h20100);
      chk("blank write 0 data", s_wdata, 12'h100);
      cyc();
      chk("blank write 1 we", s_we, 1);
      chk("blank write 1 addr", s_addr, 18'h20101);
      cyc(); cyc();
      bus.wr_valid = 0;
      cyc(); cyc();

      // swap with empty hold
      bus.swap_req = 1;
      cyc();
      bus.swap_req = 0; bus.wr_valid = 1; rdy_cnt = 0;
      repeat (9) cyc();
      chk("pend wr_ready count", rdy_cnt, 0);
      chk("pend flag", s_pend, 1);
      bus.frame_start = 1;
      cyc();
      chk("pend at frame_start", s_pend, 1);
      chk("front before swap", s_front, 0);
      bus.frame_start = 0; bus.wr_valid = 0; done_cnt = 0;
      cyc();
      chk("swapped front", s_front, 1);
      chk("swap_done pulse", s_done, 1);
      chk("pend cleared", s_pend, 0);
      cyc();
      chk("swap_done pulses", done_cnt, 1);
      bus.wr_valid = 1;
      cyc();
      bus.wr_valid = 0;
      cyc();
      chk("post-swap we", s_we, 1);
      chk("post-swap bank", s_addr[AW], 0);

      // held write blocks swap at frame_start under continuous display
      bus.disp_req = 1; bus.disp_addr = 17'h00020; bus.wr_valid = 1;
      cyc();
      bus.wr_valid = 0; bus.swap_req = 1;
      cyc();
      bus.swap_req = 0;
      cyc(); cyc();
      bus.frame_start = 1;
      cyc();
      bus.frame_start = 0;
      cyc();
      chk("deferred front", s_front, 1);
      chk("deferred pend", s_pend, 1);
      bus.disp_req = 0;
      cyc();
      chk("drain we", s_we, 1);
      chk("drain bank", s_addr[AW], 0);
      cyc();
      chk("drained idle we", s_we, 0);
      bus.frame_start = 1;
      cyc();
      bus.frame_start = 0;
      cyc();
      chk("late swap front", s_front, 0);
      chk("late swap_done", s_done, 1);

      // swap_req coinciding with frame_start
      bus.swap_req = 1; bus.frame_start = 1;
      cyc();
      bus.swap_req = 0; bus.frame_start = 0;
      cyc();
      chk("coincident pend", s_pend, 1);
      chk("coincident front", s_front, 0);
      cyc(); cyc();
      bus.wr_valid = 1; bus.frame_start = 1;
      cyc();
      bus.wr_valid = 0; bus.frame_start = 0;
      cyc();
      chk("coincident swap front", s_front, 1);
      chk("coincident pend cleared", s_pend, 0);
      chk("stall reload at frame_start", s_stall, 1);
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
